seq_detect_prog: RTL

//  Programmable serial bit-pattern detector; generalises the fixed 1101 Moore detector.

---
 rtl/seq_detect_prog.sv | 80 ++++++++
 1 files changed

// File: rtl/seq_detect_prog.sv
// Purpose: programmable serial bit-pattern detector (1..MAX_LEN bits, overlap selectable).
// Latency: found pulses one cycle after the edge that accepts the completing bit.
// Backpressure: none; d_valid qualifies input, idle cycles hold state. Option: MATCH_CNT_EN adds match_cnt.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
`ifdef MATCH_CNT_EN
  ,
  parameter int CNT_W   = 8
`endif
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               d_in,
  input  logic               d_valid,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               clear,
  output logic               found
`ifdef MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  // hist[0] is the most recent bit; fill counts how many history bits are genuine.
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_n;
  logic               accept;
  logic               len_ok;
  logic               bits_eq;
  logic               match;

  // Next history/fill and match decision for the bit offered this cycle.
  always_comb begin
    accept  = d_valid && !clear;
    hist_n  = {hist[MAX_LEN-2:0], d_in};
    fill_n  = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
    len_ok  = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
    bits_eq = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < pat_len) && (hist_n[i] != pattern[i])) begin
        bits_eq = 1'b0;
      end
    end
    match = accept && len_ok && (fill_n >= pat_len) && bits_eq;
  end

  // History shift, fill tracking and registered match pulse; non-overlap mode restarts fill on a hit.
  always_ff @(posedge clock) begin
    if (!rst_n || clear) begin
      hist  <= '0;
      fill  <= '0;
      found <= 1'b0;
    end else begin
      found <= match;
      if (accept) begin
        hist <= hist_n;
        fill <= (match && !overlap) ? '0 : fill_n;
      end
    end
  end

`ifdef MATCH_CNT_EN
  // Saturating count of matches; sticks at all-ones rather than wrapping.
  always_ff @(posedge clock) begin
    if (!rst_n || clear) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != '1)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`else
  // Without the counter, found is the only result this block produces.
`endif

endmodule
